// File: rtl/mem_stage_pkg.sv
// Shared encodings for the MEM pipeline stage: access sizes, MEM control bits, FSM states.
package mem_stage_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int unsigned MC_BRANCH = 0;
    localparam int unsigned MC_READ   = 1;
    localparam int unsigned MC_WRITE  = 2;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/mem_stage_ws_dm_be.sv
// Byte-enabled word memory: synchronous write per byte lane, asynchronous read.
module dm_be #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = 8
) (
    input  logic          clk,
    input  logic [3:0]    we,
    input  logic [AW-1:0] idx,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int unsigned b = 0; b < 4; b++) begin
            if (we[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/mem_stage_ws.sv
// MEM pipeline stage: sub-word loads/stores with wait states, branch resolve, MEM/WB register.
module mem_stage_ws
    import mem_stage_pkg::*;
#(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned MEM_DEPTH   = 256,
    parameter int unsigned REG_W       = 5,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_result,
    input  logic              i_zero,
    input  logic [DATA_W-1:0] i_branch_pc,
    input  logic [DATA_W-1:0] i_read_data2,
    input  logic [REG_W-1:0]  i_write_reg,
    input  logic [1:0]        i_WB_control,
    input  logic [2:0]        i_MEM_control,
    input  logic [1:0]        i_size,
    input  logic              i_unsigned,
    input  logic              i_branch_ne,
    output logic              o_stall,
    output logic              o_branch,
    output logic [DATA_W-1:0] o_branch_pc,
    output logic              o_valid,
    output logic [REG_W-1:0]  o_write_reg,
    output logic [DATA_W-1:0] o_write_data,
    output logic [DATA_W-1:0] o_result,
    output logic [1:0]        o_WB_control,
    output logic              o_misaligned
);

    localparam int unsigned AW   = $clog2(MEM_DEPTH);
    localparam logic [3:0]  LAST = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    state_t      state, state_n;
    logic [3:0]  cnt, cnt_n;
    logic        complete;
    logic        is_rd, is_wr, aligned, mem_op, misaligned;
    logic [1:0]  off;
    logic [3:0]  be, mem_we;
    logic [31:0] wdata, rdata, lane, ld_data, wd_next;

    assign is_rd      = i_MEM_control[MC_READ];
    assign is_wr      = i_MEM_control[MC_WRITE];
    assign off        = i_result[1:0];
    assign mem_op     = i_valid & (is_rd | is_wr) & aligned;
    assign misaligned = i_valid & (is_rd | is_wr) & ~aligned;

    assign o_branch    = i_valid & i_MEM_control[MC_BRANCH] & (i_zero ^ i_branch_ne);
    assign o_branch_pc = i_branch_pc;

    // Lane select, store replication and load extension; size 11 behaves as word.
    always_comb begin
        aligned = 1'b1;
        be      = 4'b1111;
        wdata   = i_read_data2;
        lane    = rdata >> {off, 3'b000};
        ld_data = rdata;
        case (i_size)
            SZ_BYTE: begin
                be      = 4'b0001 << off;
                wdata   = {4{i_read_data2[7:0]}};
                ld_data = i_unsigned ? {24'd0, lane[7:0]} : {{24{lane[7]}}, lane[7:0]};
            end
            SZ_HALF: begin
                aligned = ~off[0];
                be      = off[1] ? 4'b1100 : 4'b0011;
                wdata   = {2{i_read_data2[15:0]}};
                ld_data = i_unsigned ? {16'd0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
            end
            default: aligned = (off == 2'b00);
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        o_stall  = 1'b0;
        complete = 1'b0;
        case (state)
            IDLE: begin
                if (mem_op) begin
                    if (WAIT_STATES == 0) begin
                        complete = 1'b1;
                    end else begin
                        o_stall = 1'b1;
                        state_n = WAIT;
                        cnt_n   = '0;
                    end
                end
            end
            WAIT: begin
                if (cnt == LAST) begin
                    complete = 1'b1;
                    state_n  = IDLE;
                    cnt_n    = '0;
                end else begin
                    o_stall = 1'b1;
                    cnt_n   = cnt + 4'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign mem_we  = (complete & mem_op & is_wr) ? be : '0;
    assign wd_next = (complete & mem_op & is_rd & ~is_wr) ? ld_data : '0;

    dm_be #(
        .DEPTH (MEM_DEPTH),
        .AW    (AW)
    ) u_dm (
        .clk   (i_clk),
        .we    (mem_we),
        .idx   (i_result[AW+1:2]),
        .wdata (wdata),
        .rdata (rdata)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid      <= 1'b0;
            o_misaligned <= 1'b0;
            o_WB_control <= '0;
            o_write_reg  <= '0;
            o_write_data <= '0;
            o_result     <= '0;
        end else if (o_stall) begin
            o_valid      <= 1'b0;
            o_WB_control <= '0;
        end else begin
            o_valid      <= i_valid;
            o_misaligned <= misaligned;
            o_WB_control <= misaligned ? 2'b00 : i_WB_control;
            o_write_reg  <= i_write_reg;
            o_write_data <= wd_next;
            o_result     <= i_result;
        end
    end

endmodule

// File: tb/tb_mem_stage_ws.sv
// Scoreboard bench for mem_stage_ws: two instances (0 and 2 wait states) share one stimulus bus.
module tb_mem_stage_ws;

    typedef struct packed {
        logic [4:0]  wr;
        logic [31:0] res;
        logic [31:0] wd;
        logic [1:0]  wbc;
        logic        mis;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, sel;
    logic        i_valid, i_zero, i_unsigned, i_branch_ne;
    logic [31:0] i_result, i_branch_pc, i_read_data2;
    logic [4:0]  i_write_reg;
    logic [1:0]  i_WB_control, i_size;
    logic [2:0]  i_MEM_control;

    logic        o_stall_a [2], o_branch_a [2], o_valid_a [2], o_mis_a [2];
    logic [31:0] o_bpc_a [2], o_wd_a [2], o_res_a [2];
    logic [4:0]  o_wr_a [2];
    logic [1:0]  o_wbc_a [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_stage_ws #(
            .DATA_W      (32),
            .MEM_DEPTH   (256),
            .REG_W       (5),
            .WAIT_STATES ((g == 0) ? 0 : 2)
        ) u_dut (
            .i_clk         (clk),
            .i_rst_n       (rst_n),
            .i_valid       (i_valid && (sel == 1'(g))),
            .i_result      (i_result),
            .i_zero        (i_zero),
            .i_branch_pc   (i_branch_pc),
            .i_read_data2  (i_read_data2),
            .i_write_reg   (i_write_reg),
            .i_WB_control  (i_WB_control),
            .i_MEM_control (i_MEM_control),
            .i_size        (i_size),
            .i_unsigned    (i_unsigned),
            .i_branch_ne   (i_branch_ne),
            .o_stall       (o_stall_a[g]),
            .o_branch      (o_branch_a[g]),
            .o_branch_pc   (o_bpc_a[g]),
            .o_valid       (o_valid_a[g]),
            .o_write_reg   (o_wr_a[g]),
            .o_write_data  (o_wd_a[g]),
            .o_result      (o_res_a[g]),
            .o_WB_control  (o_wbc_a[g]),
            .o_misaligned  (o_mis_a[g])
        );
    end

    logic        o_stall, o_branch, o_valid, o_misaligned;
    logic [31:0] o_branch_pc, o_write_data, o_result;
    logic [4:0]  o_write_reg;
    logic [1:0]  o_WB_control;
    assign o_stall      = o_stall_a[sel];
    assign o_branch     = o_branch_a[sel];
    assign o_branch_pc  = o_bpc_a[sel];
    assign o_valid      = o_valid_a[sel];
    assign o_write_reg  = o_wr_a[sel];
    assign o_write_data = o_wd_a[sel];
    assign o_result     = o_res_a[sel];
    assign o_WB_control = o_wbc_a[sel];
    assign o_misaligned = o_mis_a[sel];

    int          vectors = 0;
    int          miscompares = 0;
    int          ws;
    exp_t        sb [$];
    logic [31:0] mdl [256];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Every edge that loads a real instruction into MEM/WB raises o_valid; one record per capture.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && o_valid === 1'b1) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_capture actual=valid required=bubble");
            end else begin
                e = sb.pop_front();
                chk("memwb", {o_write_reg, o_result, o_write_data, o_WB_control, o_misaligned}, e);
            end
        end
    end

    function automatic logic [31:0] load_val(input logic [31:0] w, input int off,
                                             input logic [1:0] sz, input logic uns);
        logic [31:0] v;
        if (sz == 2'd0) begin
            v = (w >> (8 * off)) % 256;
            if (!uns && v >= 128) v = v + 32'hFFFFFF00;
        end else if (sz == 2'd1) begin
            v = (w >> (8 * off)) % 65536;
            if (!uns && v >= 32768) v = v + 32'hFFFF0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    function automatic logic [31:0] store_val(input logic [31:0] w, input int off,
                                              input logic [1:0] sz, input logic [31:0] d);
        logic [31:0] m;
        if (sz == 2'd0) begin
            m = 32'hFF << (8 * off);
            return (w & ~m) | ((d % 256) << (8 * off));
        end else if (sz == 2'd1) begin
            m = 32'hFFFF << (8 * off);
            return (w & ~m) | ((d % 65536) << (8 * off));
        end
        return d;
    endfunction

    task automatic issue(input logic v, input logic [2:0] mc, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] d, input logic z, input logic ne);
        exp_t        e;
        logic        rd, wr, mem, mis;
        int          widx, off, stalls, guard, exp_stall;
        logic [31:0] bpc;
        rd   = mc[1];
        wr   = mc[2];
        mem  = v && (rd || wr);
        off  = a % 4;
        widx = (a / 4) % 256;
        mis  = mem && ((sz == 2'd1 && off % 2 != 0) || (sz >= 2'd2 && off != 0));
        bpc  = $urandom;
        e.wr  = 5'($urandom_range(0, 31));
        e.wbc = 2'($urandom_range(0, 3));
        e.res = a;
        e.mis = mis;
        e.wd  = (mem && !mis && rd && !wr) ? load_val(mdl[widx], off, sz, uns) : 32'd0;
        if (mem && !mis && wr) mdl[widx] = store_val(mdl[widx], off, sz, d);
        exp_stall = (mem && !mis) ? ws : 0;

        i_valid = v; i_MEM_control = mc; i_size = sz; i_unsigned = uns; i_result = a;
        i_read_data2 = d; i_zero = z; i_branch_ne = ne; i_branch_pc = bpc;
        i_write_reg = e.wr; i_WB_control = e.wbc;
        if (v) begin
            if (mis) e.wbc = 2'b00;
            sb.push_back(e);
        end

        @(negedge clk);
        chk("branch", {o_branch, o_branch_pc}, {v && mc[0] && (z != ne), bpc});
        stalls = 0;
        guard  = 0;
        while (o_stall === 1'b1 && guard < 40) begin
            stalls++;
            guard++;
            @(negedge clk);
        end
        chk("stall_cycles", stalls, exp_stall);
        @(posedge clk);
        #1;
        i_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        i_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rand_op();
        int          k, sz, hi, widx, off;
        logic [2:0]  mc;
        logic [31:0] a;
        k    = $urandom_range(0, 4);
        sz   = $urandom_range(0, 3);
        hi   = $urandom_range(0, 7);
        widx = $urandom_range(0, 15);
        off  = $urandom_range(0, 3);
        case (k)
            0: mc = 3'b010;
            1: mc = 3'b100;
            2: mc = 3'b110;
            3: mc = 3'b001;
            default: mc = 3'b000;
        endcase
        a = (k <= 2) ? 32'((hi << 10) + (widx << 2) + off) : $urandom;
        issue(1'b1, mc, 2'(sz), 1'($urandom_range(0, 1)), a, $urandom,
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        if ($urandom_range(0, 3) == 0) idle(1);
    endtask

    task automatic run_phase(input logic p);
        sel = p;
        ws  = p ? 2 : 0;
        for (int i = 0; i < 16; i++) issue(1'b1, 3'b100, 2'd2, 1'b0, 32'(i * 4), $urandom, 1'b0, 1'b0);
        issue(1'b1, 3'b100, 2'd2, 1'b0, 32'h10,  32'hDEADBEEF, 1'b0, 1'b0);
        issue(1'b1, 3'b010, 2'd2, 1'b0, 32'h10,  32'd0,        1'b0, 1'b0);
        issue(1'b1, 3'b010, 2'd0, 1'b0, 32'h13,  32'd0,        1'b0, 1'b0);
        issue(1'b1, 3'b010, 2'd0, 1'b1, 32'h13,  32'd0,        1'b0, 1'b0);
        issue(1'b1, 3'b010, 2'd1, 1'b0, 32'h12,  32'd0,        1'b0, 1'b0);
        issue(1'b1, 3'b100, 2'd0, 1'b0, 32'h11,  32'h55,       1'b0, 1'b0);
        issue(1'b1, 3'b010, 2'd2, 1'b0, 32'h10,  32'd0,        1'b0, 1'b0);
        issue(1'b1, 3'b010, 2'd1, 1'b0, 32'h11,  32'd0,        1'b0, 1'b0);
        issue(1'b1, 3'b100, 2'd2, 1'b0, 32'h12,  32'hCAFEF00D, 1'b0, 1'b0);
        issue(1'b1, 3'b010, 2'd2, 1'b0, 32'h10,  32'd0,        1'b0, 1'b0);
        issue(1'b1, 3'b100, 2'd2, 1'b0, 32'h400, 32'h12345678, 1'b0, 1'b0);
        issue(1'b1, 3'b010, 2'd2, 1'b0, 32'h000, 32'd0,        1'b0, 1'b0);
        issue(1'b1, 3'b110, 2'd2, 1'b0, 32'h8,   32'hA5A5A5A5, 1'b0, 1'b0);
        issue(1'b1, 3'b010, 2'd3, 1'b1, 32'h8,   32'd0,        1'b0, 1'b0);
        issue(1'b1, 3'b001, 2'd0, 1'b0, 32'h0,   32'd0,        1'b1, 1'b0);
        issue(1'b1, 3'b001, 2'd0, 1'b0, 32'h0,   32'd0,        1'b1, 1'b1);
        issue(1'b0, 3'b001, 2'd0, 1'b0, 32'h0,   32'd0,        1'b1, 1'b0);
        issue(1'b1, 3'b001, 2'd0, 1'b0, 32'h0,   32'd0,        1'b0, 1'b1);
        for (int i = 0; i < 120; i++) rand_op();
        idle(3);
        chk("drain", sb.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        sel = 1'b0; rst_n = 1'b0; i_valid = 1'b0; i_zero = 1'b0; i_unsigned = 1'b0;
        i_branch_ne = 1'b0; i_result = '0; i_branch_pc = '0; i_read_data2 = '0;
        i_write_reg = '0; i_WB_control = '0; i_size = '0; i_MEM_control = '0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            #1;
            chk("reset_state", {o_valid, o_misaligned, o_WB_control, o_write_reg,
                                o_write_data, o_result, o_stall}, '0);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_phase(1'b0);
        run_phase(1'b1);

        // Abort a 2-wait-state store by resetting during its second cycle.
        idle(2);
        i_valid = 1'b1; i_MEM_control = 3'b100; i_size = 2'd2; i_result = 32'h10;
        i_read_data2 = 32'h0BADF00D; i_write_reg = 5'd3; i_WB_control = 2'b11;
        @(negedge clk);
        chk("abort_stall_c1", o_stall, 1'b1);
        @(posedge clk);
        #2;
        rst_n   = 1'b0;
        i_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("after_reset", {o_stall, o_valid, o_WB_control}, '0);
        @(posedge clk);
        #1;
        issue(1'b1, 3'b010, 2'd2, 1'b0, 32'h10, 32'd0, 1'b0, 1'b0);
        idle(3);
        chk("drain_final", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
